// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses PLL reset, filters lock, releases staged resets.
// Define RELOCK_COUNT_EN to build the saturating lock-loss counter.
module pll_reset_seq #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int LOCK_FILTER    = 256,
    parameter int HOLD_CYCLES    = 64,
    parameter int STAGE_GAP      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       periph_rst_n_o,
    output logic       locked_o,
    output logic [7:0] relock_cnt_o
);

    localparam int M0 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ?
                        PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int M1 = (LOCK_FILTER > HOLD_CYCLES) ?
                        LOCK_FILTER : HOLD_CYCLES;
    localparam int M2 = (M0 > M1) ? M0 : M1;
    localparam int MAX_C = (M2 > STAGE_GAP) ? M2 : STAGE_GAP;
    localparam int CW = (MAX_C > 2) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] T_RST   = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] T_TO    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] T_FILT  = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] T_HOLD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] T_STAGE = CW'(STAGE_GAP - 1);

    localparam logic [2:0] S_PLL_RST = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_FILTER  = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_STAGE   = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;

    logic          lock_m;
    logic          lock_s;
    logic [2:0]    state;
    logic [2:0]    state_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock_i;
            lock_s <= lock_m;
        end
    end

    // Lock loss is tested before any terminal count so it always wins.
    always_comb begin
        state_d = state;
        unique case (1'b1)
            (state == S_PLL_RST):
                if (cnt == T_RST) state_d = S_WAIT;
            (state == S_WAIT):
                if (lock_s) state_d = S_FILTER;
                else if (cnt == T_TO) state_d = S_PLL_RST;
            (state == S_FILTER):
                if (!lock_s) state_d = S_WAIT;
                else if (cnt == T_FILT) state_d = S_HOLD;
            (state == S_HOLD):
                if (!lock_s) state_d = S_WAIT;
                else if (cnt == T_HOLD) state_d = S_STAGE;
            (state == S_STAGE):
                if (!lock_s) state_d = S_WAIT;
                else if (cnt == T_STAGE) state_d = S_RUN;
            (state == S_RUN):
                if (!lock_s) state_d = S_WAIT;
            default:
                state_d = S_PLL_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_PLL_RST;
            cnt            <= '0;
            pll_reset_o    <= 1'b1;
            sys_rst_n_o    <= 1'b0;
            periph_rst_n_o <= 1'b0;
            locked_o       <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= (state_d != state) ? '0 : cnt + 1'b1;
            pll_reset_o    <= (state_d == S_PLL_RST);
            sys_rst_n_o    <= (state_d == S_STAGE) || (state_d == S_RUN);
            periph_rst_n_o <= (state_d == S_RUN);
            locked_o       <= (state_d == S_RUN);
        end
    end

`ifdef RELOCK_COUNT_EN
    logic [7:0] relock_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_q <= 8'd0;
        end else if ((state == S_RUN) && !lock_s && (relock_q != 8'hFF)) begin
            relock_q <= relock_q + 8'd1;
        end
    end

    assign relock_cnt_o = relock_q;
`else
    assign relock_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Scoreboard bench for pll_reset_seq with short test parameters.
// Expected outputs per cycle are queued at drive time and popped at negedge.
module tb_pll_reset_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_lock_i = 1'b0;
    logic       pll_reset_o;
    logic       sys_rst_n_o;
    logic       periph_rst_n_o;
    logic       locked_o;
    logic [7:0] relock_cnt_o;

`ifdef RELOCK_COUNT_EN
    localparam bit RL_EN = 1'b1;
`else
    localparam bit RL_EN = 1'b0;
`endif

    pll_reset_seq #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (50),
        .LOCK_FILTER   (8),
        .HOLD_CYCLES   (6),
        .STAGE_GAP     (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pll_lock_i    (pll_lock_i),
        .pll_reset_o   (pll_reset_o),
        .sys_rst_n_o   (sys_rst_n_o),
        .periph_rst_n_o(periph_rst_n_o),
        .locked_o      (locked_o),
        .relock_cnt_o  (relock_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pll;
        logic       sys;
        logic       per;
        logic [7:0] rl;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    int   rl_m = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pll_reset", 32'(pll_reset_o), 32'(e.pll));
            chk("sys_rst_n", 32'(sys_rst_n_o), 32'(e.sys));
            chk("periph_rst_n", 32'(periph_rst_n_o), 32'(e.per));
            chk("locked", 32'(locked_o), 32'(e.per));
            chk("relock_cnt", 32'(relock_cnt_o), 32'(e.rl));
        end
    end

    task automatic push(input logic pll, input logic sys, input logic per,
                        input int rl);
        exp_t e;
        e.pll = pll;
        e.sys = sys;
        e.per = per;
        e.rl  = 8'(rl);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        pll_lock_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n = 0;
        rl_m = 0;
        push(1'b1, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
    endtask

    // One-cycle lock drop from RUN; outputs fall 3 cycles later, then restage.
    task automatic lose_once();
        int d;
        int rl_b;
        d = n + 1;
        rl_b = rl_m;
        if (RL_EN) rl_m = (rl_m < 255) ? rl_m + 1 : 255;
        for (int k = 0; k < 23; k++) begin
            tick();
            if (n == d) pll_lock_i = 1'b0;
            if (n == d + 1) pll_lock_i = 1'b1;
            push(1'b0, !(n >= d + 3 && n < d + 18),
                 !(n >= d + 3 && n < d + 21),
                 (n >= d + 3) ? rl_m : rl_b);
        end
    endtask

    initial begin
        int l;
        int d;

        // Clean lock: lock rises after edge 10
        do_reset();
        l = 10;
        while (n < l + 25) begin
            tick();
            if (n == l) pll_lock_i = 1'b1;
            push(n < 4, n >= l + 17, n >= l + 20, 0);
        end

        // No lock: periodic 4-cycle PLL reset pulses every 54 cycles
        do_reset();
        while (n < 170) begin
            tick();
            push((n % 54) < 4, 1'b0, 1'b0, 0);
        end

        // Glitchy lock: 5 high, 1 low, then steady
        do_reset();
        l = 10;
        while (n < 45) begin
            tick();
            if (n == l) pll_lock_i = 1'b1;
            if (n == l + 5) pll_lock_i = 1'b0;
            if (n == l + 6) pll_lock_i = 1'b1;
            push(n < 4, n >= l + 23, n >= l + 26, 0);
        end

        // Lock loss in RUN, then saturation of the relock counter
        lose_once();
        for (int i = 0; i < 300; i++) lose_once();

        // Async reset while in STAGE
        d = n + 1;
        while (n < d + 19) begin
            tick();
            if (n == d) pll_lock_i = 1'b0;
            if (n == d + 1) pll_lock_i = 1'b1;
            push(1'b0, !(n >= d + 3 && n < d + 18), n < d + 3,
                 (n >= d + 3 && RL_EN) ? 255 : (RL_EN ? 255 : 0));
        end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_pll_reset", 32'(pll_reset_o), 32'd1);
        chk("async_sys_rst_n", 32'(sys_rst_n_o), 32'd0);
        chk("async_periph_rst_n", 32'(periph_rst_n_o), 32'd0);
        chk("async_locked", 32'(locked_o), 32'd0);
        chk("async_relock_cnt", 32'(relock_cnt_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
